// File: rtl/servo_pkg.sv
// Shared servo constants, scan state encoding and command strobe bundle.
package servo_pkg;

  // Frame and pulse-width timing in PCLK cycles at 100 MHz.
  localparam int unsigned SERVO_PWM_PERIOD   = 2000000; // 20 ms frame
  localparam int unsigned SERVO_CMD_OFFSET   = 1000000; // mid-frame command point
  localparam int unsigned SERVO_SETTLE_TICKS = 255;
  localparam int unsigned SERVO_PW_MIN       = 100000;  // 1.0 ms pulse
  localparam int unsigned SERVO_PW_CENTER    = 150000;  // 1.5 ms pulse
  localparam int unsigned SERVO_PW_MAX       = 200000;  // 2.0 ms pulse

  // Scan controller states.
  typedef logic [2:0] scan_state_t;
  localparam scan_state_t StIdle   = 3'd0;
  localparam scan_state_t StSweepX = 3'd1;
  localparam scan_state_t StStepY  = 3'd2;
  localparam scan_state_t StReturn = 3'd3;
  localparam scan_state_t StSettle = 3'd4;

  // One-cycle command strobes for both axes.
  typedef struct packed {
    logic x_neutral;
    logic x_forward;
    logic x_reverse;
    logic x_return;
    logic y_neutral;
    logic y_forward;
    logic y_return;
  } servo_cmd_t;

  // True when row is the final row of a scan with rows rows (rows >= 1).
  function automatic logic is_last_row(logic [7:0] row, logic [7:0] rows);
    return ({1'b0, row} + 9'd1) >= {1'b0, rows};
  endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running PWM frame counter with a single-cycle mid-frame command tick.
module servo_frame_timer #(
  parameter int unsigned PERIOD = 2000000,
  parameter int unsigned OFFSET = 1000000
) (
  input  logic PCLK,
  input  logic PRESET,
  output logic cmd_tick
);

  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [TW-1:0] LastCount = TW'(PERIOD - 1);
  localparam logic [TW-1:0] TickCount = TW'(OFFSET);

  logic [TW-1:0] timer_q;

  // Count 0..PERIOD-1 and wrap; runs regardless of scan state.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      timer_q <= '0;
    end else if (timer_q == LastCount) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + TW'(1);
    end
  end

  assign cmd_tick = (timer_q == TickCount);

endmodule

// File: rtl/servo_scan_sequencer.sv
// Raster-scan sequencer: sweeps X, steps Y, alternates X direction per row,
// then returns both axes to zero and waits for them to settle.
module servo_scan_sequencer
  import servo_pkg::*;
#(
  parameter int unsigned PWM_PERIOD   = SERVO_PWM_PERIOD,
  parameter int unsigned CMD_OFFSET   = SERVO_CMD_OFFSET,
  parameter int unsigned SETTLE_TICKS = SERVO_SETTLE_TICKS
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] cfg_x_steps,
  input  logic [15:0] cfg_y_steps,
  input  logic [7:0]  cfg_rows,
  output logic        x_cmd_neutral,
  output logic        x_cmd_forward,
  output logic        x_cmd_reverse,
  output logic        x_cmd_return,
  output logic        y_cmd_neutral,
  output logic        y_cmd_forward,
  output logic        y_cmd_return,
  output logic        busy,
  output logic        done,
  output logic        aborted,
  output logic [7:0]  row_idx
);

  localparam logic [15:0] SettleLast = 16'(SETTLE_TICKS - 1);

  logic cmd_tick;

  scan_state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  row_q, row_d;
  logic [15:0] x_steps_q, x_steps_d;
  logic [15:0] y_steps_q, y_steps_d;
  logic [7:0]  rows_q, rows_d;
  servo_cmd_t  cmd_q, cmd_d;
  logic        done_q, done_d;
  logic        aborted_q, aborted_d;

  servo_frame_timer #(
    .PERIOD (PWM_PERIOD),
    .OFFSET (CMD_OFFSET)
  ) u_frame_timer (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .cmd_tick (cmd_tick)
  );

  // Next-state and strobe decode; abort outranks the tick-aligned actions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    x_steps_d = x_steps_q;
    y_steps_d = y_steps_q;
    rows_d    = rows_q;
    cmd_d     = '0;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    if (state_q == StIdle) begin
      if (start) begin
        x_steps_d = cfg_x_steps;
        y_steps_d = cfg_y_steps;
        rows_d    = cfg_rows;
        cnt_d     = '0;
        row_d     = '0;
        state_d   = (cfg_rows != 8'd0) ? StSweepX : StReturn;
      end
    end else if (abort) begin
      cmd_d.x_neutral = 1'b1;
      cmd_d.y_neutral = 1'b1;
      aborted_d       = 1'b1;
      cnt_d           = '0;
      state_d         = StIdle;
    end else if (cmd_tick) begin
      case (state_q)
        StSweepX: begin
          if (cnt_q == x_steps_q) begin
            cmd_d.x_neutral = 1'b1;
            cnt_d           = '0;
            state_d         = is_last_row(row_q, rows_q) ? StReturn : StStepY;
          end else begin
            if (cnt_q == 16'd0) begin
              // Serpentine raster: odd rows run X backwards.
              if (row_q[0]) cmd_d.x_reverse = 1'b1;
              else          cmd_d.x_forward = 1'b1;
            end
            cnt_d = cnt_q + 16'd1;
          end
        end
        StStepY: begin
          if (cnt_q == y_steps_q) begin
            cmd_d.y_neutral = 1'b1;
            cnt_d           = '0;
            row_d           = row_q + 8'd1;
            state_d         = StSweepX;
          end else begin
            if (cnt_q == 16'd0) cmd_d.y_forward = 1'b1;
            cnt_d = cnt_q + 16'd1;
          end
        end
        StReturn: begin
          cmd_d.x_return = 1'b1;
          cmd_d.y_return = 1'b1;
          cnt_d          = '0;
          state_d        = StSettle;
        end
        StSettle: begin
          if (cnt_q == SettleLast) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State, latched configuration and registered strobes.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      row_q     <= '0;
      x_steps_q <= '0;
      y_steps_q <= '0;
      rows_q    <= '0;
      cmd_q     <= '0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      x_steps_q <= x_steps_d;
      y_steps_q <= y_steps_d;
      rows_q    <= rows_d;
      cmd_q     <= cmd_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign x_cmd_neutral = cmd_q.x_neutral;
  assign x_cmd_forward = cmd_q.x_forward;
  assign x_cmd_reverse = cmd_q.x_reverse;
  assign x_cmd_return  = cmd_q.x_return;
  assign y_cmd_neutral = cmd_q.y_neutral;
  assign y_cmd_forward = cmd_q.y_forward;
  assign y_cmd_return  = cmd_q.y_return;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign row_idx       = row_q;

endmodule

// File: tb/tb_servo_scan_sequencer.sv
// Scoreboard bench: each scan is expanded into its expected strobe timeline
// from the scan rules; a monitor compares every cycle the DUT drives an output.
module tb_servo_scan_sequencer;

  localparam int unsigned PERIOD = 100;
  localparam int unsigned OFFSET = 50;
  localparam int unsigned SETTLE = 4;

  localparam logic [8:0] M_XNEU = 9'h001;
  localparam logic [8:0] M_XFWD = 9'h002;
  localparam logic [8:0] M_XREV = 9'h004;
  localparam logic [8:0] M_XRET = 9'h008;
  localparam logic [8:0] M_YNEU = 9'h010;
  localparam logic [8:0] M_YFWD = 9'h020;
  localparam logic [8:0] M_YRET = 9'h040;
  localparam logic [8:0] M_DONE = 9'h080;
  localparam logic [8:0] M_ABT  = 9'h100;

  logic        PCLK;
  logic        PRESET;
  logic        start;
  logic        abort;
  logic [15:0] cfg_x_steps;
  logic [15:0] cfg_y_steps;
  logic [7:0]  cfg_rows;
  logic        x_cmd_neutral, x_cmd_forward, x_cmd_reverse, x_cmd_return;
  logic        y_cmd_neutral, y_cmd_forward, y_cmd_return;
  logic        busy, done, aborted;
  logic [7:0]  row_idx;

  typedef struct {
    longint     cyc;
    logic [8:0] mask;
    int         row;   // -1: row not checked
    bit         busy;
  } ev_t;

  ev_t    sb[$];
  longint cyc;
  int     checks;
  int     failures;

  servo_scan_sequencer #(
    .PWM_PERIOD   (PERIOD),
    .CMD_OFFSET   (OFFSET),
    .SETTLE_TICKS (SETTLE)
  ) dut (
    .PCLK          (PCLK),
    .PRESET        (PRESET),
    .start         (start),
    .abort         (abort),
    .cfg_x_steps   (cfg_x_steps),
    .cfg_y_steps   (cfg_y_steps),
    .cfg_rows      (cfg_rows),
    .x_cmd_neutral (x_cmd_neutral),
    .x_cmd_forward (x_cmd_forward),
    .x_cmd_reverse (x_cmd_reverse),
    .x_cmd_return  (x_cmd_return),
    .y_cmd_neutral (y_cmd_neutral),
    .y_cmd_forward (y_cmd_forward),
    .y_cmd_return  (y_cmd_return),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .row_idx       (row_idx)
  );

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  // Cycle index: the frame timer holds cyc % PERIOD during cycle cyc.
  always @(posedge PCLK) begin
    if (PRESET) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_ev(input longint c, input logic [8:0] m, input int row, input bit b);
    ev_t e;
    e.cyc  = c;
    e.mask = m;
    e.row  = row;
    e.busy = b;
    sb.push_back(e);
  endtask

  // Cycle in which the response to the k-th command tick after start is visible.
  function automatic longint ev_cyc(input longint t1, input int k);
    return t1 + longint'(k - 1) * PERIOD + 1;
  endfunction

  // Expand a scan into its expected timeline; start sampled during cycle s.
  task automatic build(input longint s, input int x, input int y, input int rows,
                       output longint t1, output longint d);
    int k;
    int lr;
    t1 = s - (s % PERIOD) + OFFSET;
    if (t1 <= s) t1 += PERIOD;
    k = 1;
    for (int r = 0; r < rows; r++) begin
      if (x > 0) push_ev(ev_cyc(t1, k), (r % 2 == 1) ? M_XREV : M_XFWD, r, 1'b1);
      k += x;
      push_ev(ev_cyc(t1, k), M_XNEU, r, 1'b1);
      k++;
      if (r < rows - 1) begin
        if (y > 0) push_ev(ev_cyc(t1, k), M_YFWD, r, 1'b1);
        k += y;
        push_ev(ev_cyc(t1, k), M_YNEU, r + 1, 1'b1);
        k++;
      end
    end
    lr = (rows > 0) ? rows - 1 : 0;
    push_ev(ev_cyc(t1, k), M_XRET | M_YRET, lr, 1'b1);
    k += SETTLE;
    push_ev(ev_cyc(t1, k), M_DONE, lr, 1'b0);
    d = ev_cyc(t1, k);
  endtask

  task automatic wait_until(input longint c);
    while (cyc < c) @(negedge PCLK);
  endtask

  // abort_mode: 0 none, 1 twenty cycles after the second sweep tick, 2 random.
  task automatic run_scan(input int x, input int y, input int rows, input int abort_mode,
                          input bit mid_start, input bit abort_with_start);
    longint s, t1, d, a, last;
    @(negedge PCLK);
    s           = cyc;
    start       = 1'b1;
    abort       = abort_with_start;
    cfg_x_steps = 16'(x);
    cfg_y_steps = 16'(y);
    cfg_rows    = 8'(rows);
    build(s, x, y, rows, t1, d);
    last = d;
    @(negedge PCLK);
    start       = 1'b0;
    abort       = 1'b0;
    cfg_x_steps = 16'($urandom);
    cfg_y_steps = 16'($urandom);
    cfg_rows    = 8'($urandom);
    chk("busy_after_start", busy, 1);
    if (mid_start) begin
      wait_until(t1 + PERIOD);
      start       = 1'b1;
      cfg_x_steps = 16'd9;
      @(negedge PCLK);
      start = 1'b0;
    end
    if (abort_mode != 0) begin
      if (abort_mode == 1) a = t1 + PERIOD + 20;
      else                 a = s + 1 + longint'($urandom_range(0, 32'(d - s - 2)));
      wait_until(a);
      abort = 1'b1;
      while (sb.size() > 0 && sb[$].cyc > a) void'(sb.pop_back());
      push_ev(a + 1, M_XNEU | M_YNEU | M_ABT, -1, 1'b0);
      @(negedge PCLK);
      abort = 1'b0;
      last  = a + 1;
    end
    wait_until(last + 2);
    chk("busy_low_after_scan", busy, 0);
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  // Monitor: every non-quiet output cycle must match the head of the scoreboard.
  always @(negedge PCLK) begin
    logic [8:0] mask;
    ev_t e;
    if (!PRESET) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_event: got nothing at cyc=%0d expected mask=%h", e.cyc, e.mask);
      end
      mask = {aborted, done, y_cmd_return, y_cmd_forward, y_cmd_neutral,
              x_cmd_return, x_cmd_reverse, x_cmd_forward, x_cmd_neutral};
      if (mask != 9'h000) begin
        checks++;
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          failures++;
          $display("FAIL unexpected_output: got mask=%h row=%0d busy=%0b at cyc=%0d expected none",
                   mask, row_idx, busy, cyc);
        end else begin
          e = sb.pop_front();
          if (e.mask != mask || e.busy != busy || (e.row >= 0 && int'(row_idx) != e.row)) begin
            failures++;
            $display("FAIL event_mismatch cyc=%0d: got mask=%h row=%0d busy=%0b expected mask=%h row=%0d busy=%0b",
                     cyc, mask, row_idx, busy, e.mask, e.row, e.busy);
          end
        end
      end
    end
  end

  initial begin
    checks      = 0;
    failures    = 0;
    PRESET      = 1'b1;
    start       = 1'b0;
    abort       = 1'b0;
    cfg_x_steps = 16'd0;
    cfg_y_steps = 16'd0;
    cfg_rows    = 8'd0;

    // Reset for three cycles, then every output idle.
    repeat (3) @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("reset_strobes", {x_cmd_neutral, x_cmd_forward, x_cmd_reverse, x_cmd_return,
                          y_cmd_neutral, y_cmd_forward, y_cmd_return}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_aborted", aborted, 0);
    chk("reset_row_idx", row_idx, 0);
    repeat (500) @(negedge PCLK);
    chk("idle_500_busy", busy, 0);

    // Directed scans.
    run_scan(3, 1, 2, 0, 1'b0, 1'b0);  // full scan
    run_scan(5, 2, 0, 0, 1'b0, 1'b0);  // zero rows
    run_scan(0, 1, 1, 0, 1'b0, 1'b0);  // zero x_steps
    run_scan(3, 1, 2, 1, 1'b0, 1'b0);  // abort mid-sweep
    run_scan(3, 1, 2, 0, 1'b0, 1'b0);  // restart after abort
    run_scan(3, 1, 2, 0, 1'b1, 1'b0);  // start + cfg change while busy

    // Abort while idle does nothing.
    @(negedge PCLK);
    abort = 1'b1;
    @(negedge PCLK);
    abort = 1'b0;
    repeat (3) @(negedge PCLK);
    chk("idle_abort_busy", busy, 0);

    // Start and abort together while idle: start wins.
    run_scan(0, 0, 0, 0, 1'b0, 1'b1);

    // Randomized scans, some aborted at a random point.
    for (int n = 0; n < 12; n++) begin
      int gap;
      gap = int'($urandom_range(0, 150));
      repeat (gap) @(negedge PCLK);
      run_scan(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
               int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? 2 : 0,
               1'b0, 1'b0);
    end

    repeat (10) @(negedge PCLK);
    chk("final_scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
